// File: rtl/instruction_loader_if.sv
// ============================================================================
// Module  : instruction_loader_if
// Brief   : Bundle between the instruction loader and its environment. The
//           environment supplies the start pulse and the UART receive bytes.
//           The loader returns memory write cycles and its status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  // Debug unit and UART receiver side
  logic                  i_start;
  logic                  i_rx_valid;
  logic [7:0]            i_rx_data;
  // Instruction memory write port and status
  logic                  o_write_instruction_mem;
  logic [ADDR_WIDTH-1:0] o_instruction_mem_addr;
  logic [31:0]           o_instruction_mem_data;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;
  logic [12:0]           o_byte_count;

  // The loader drives the memory writes and the status signals
  modport master (
    input  i_start, i_rx_valid, i_rx_data,
    output o_write_instruction_mem, o_instruction_mem_addr,
           o_instruction_mem_data, o_busy, o_done, o_error, o_byte_count
  );

  // The environment drives stimulus and observes the loader
  modport slave (
    output i_start, i_rx_valid, i_rx_data,
    input  o_write_instruction_mem, o_instruction_mem_addr,
           o_instruction_mem_data, o_busy, o_done, o_error, o_byte_count
  );
endinterface

`default_nettype wire

// File: rtl/instruction_loader.sv
// ============================================================================
// Module  : instruction_loader
// Brief   : Takes program bytes from the UART receiver and writes them one
//           after another into the byte-wide instruction memory. A load ends
//           on an aligned HALT_WORD, which is still written, or on overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_loader #(
  parameter int          MEM_BYTES  = 4096,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter int          ADDR_WIDTH = 32
) (
  input  wire                         i_clk,
  input  wire                         i_reset,
  instruction_loader_if.master        bus
);

  localparam logic [12:0] c_MEM_BYTES = 13'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                r_state;
  logic [12:0]           r_count;
  // Holds only the last three bytes. The fourth byte of a word comes straight
  // from the receive data when the halt comparison is made.
  logic [23:0]           r_sr;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic                  w_full;
  logic                  w_halt;

  assign w_full = (r_count == c_MEM_BYTES);
  assign w_halt = (r_count[1:0] == 2'd3) && ({r_sr, bus.i_rx_data} == HALT_WORD);

  // Load control FSM. All outputs are registered and change on the same edge
  // as the state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_sr    <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        S_LOAD: begin
          // A start pulse in the middle of a load is ignored on purpose
          if (bus.i_rx_valid) begin
            if (w_full) begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_write <= 1'b1;
              r_addr  <= ADDR_WIDTH'(r_count);
              r_data  <= {24'b0, bus.i_rx_data};
              r_count <= r_count + 13'd1;
              r_sr    <= {r_sr[15:0], bus.i_rx_data};
              if (w_halt) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          // Idle, done and error all wait for a start. A byte that arrives
          // in the same cycle as the start is dropped.
          if (bus.i_start) begin
            r_state <= S_LOAD;
            r_count <= '0;
            r_sr    <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.o_write_instruction_mem = r_write;
  assign bus.o_instruction_mem_addr  = r_addr;
  assign bus.o_instruction_mem_data  = r_data;
  assign bus.o_busy                  = r_busy;
  assign bus.o_done                  = r_done;
  assign bus.o_error                 = r_error;
  assign bus.o_byte_count            = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_loader.sv
// ============================================================================
// Module  : tb_instruction_loader
// Brief   : Directed self-checking bench for instruction_loader. It uses a
//           full-size instance and an instance with an 8-byte memory to
//           exercise overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_loader;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  instruction_loader_if #(.ADDR_WIDTH(32)) bus ();
  instruction_loader_if #(.ADDR_WIDTH(32)) bus8 ();

  instruction_loader #(
    .MEM_BYTES (4096),
    .HALT_WORD (32'hFFFF_FFFF),
    .ADDR_WIDTH(32)
  ) u_dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  instruction_loader #(
    .MEM_BYTES (8),
    .HALT_WORD (32'hFFFF_FFFF),
    .ADDR_WIDTH(32)
  ) u_dut8 (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus8)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Pulse start, optionally with a byte in the same cycle that must be dropped
  task automatic do_start(input logic with_byte);
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_rx_valid = with_byte;
    bus.i_rx_data  = 8'hAB;
    @(negedge clk);
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    check("start_busy", 32'(bus.o_busy), 32'd1);
    check("start_count", 32'(bus.o_byte_count), 32'd0);
    check("start_nowrite", 32'(bus.o_write_instruction_mem), 32'd0);
  endtask

  // Send one byte and check the resulting single-cycle write
  task automatic send_byte(input logic [7:0] b, input int exp_addr, input logic exp_done);
    @(negedge clk);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    check("wr_strobe", 32'(bus.o_write_instruction_mem), 32'd1);
    check("wr_addr", bus.o_instruction_mem_addr, 32'(exp_addr));
    check("wr_data", bus.o_instruction_mem_data, {24'b0, b});
    check("wr_done", 32'(bus.o_done), 32'(exp_done));
    check("wr_busy", 32'(bus.o_busy), 32'(!exp_done));
    @(negedge clk);
    check("wr_oneshot", 32'(bus.o_write_instruction_mem), 32'd0);
    check("wr_addr_hold", bus.o_instruction_mem_addr, 32'(exp_addr));
  endtask

  initial begin
    logic [7:0] prog1 [8];
    logic [7:0] prog2 [12];
    n_checks = 0;
    n_pass   = 0;
    bus.i_start = 1'b0;  bus.i_rx_valid = 1'b0;  bus.i_rx_data = 8'h00;
    bus8.i_start = 1'b0; bus8.i_rx_valid = 1'b0; bus8.i_rx_data = 8'h00;

    // Reset state, then strobes while idle must not write
    rst = 1'b1;
    #12;
    check("rst_write", 32'(bus.o_write_instruction_mem), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_error", 32'(bus.o_error), 32'd0);
    check("rst_count", 32'(bus.o_byte_count), 32'd0);
    check("rst_addr", bus.o_instruction_mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'h5A;
      @(negedge clk);
      bus.i_rx_valid = 1'b0;
      check("idle_nowrite", 32'(bus.o_write_instruction_mem), 32'd0);
    end

    // Single program ending on an aligned halt word
    prog1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_start(1'b0);
    for (int i = 0; i < 8; i++) send_byte(prog1[i], i, (i == 7));
    check("p1_count", 32'(bus.o_byte_count), 32'd8);
    check("p1_done", 32'(bus.o_done), 32'd1);
    // Bytes after completion are ignored
    @(negedge clk);
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    check("done_nowrite", 32'(bus.o_write_instruction_mem), 32'd0);
    check("done_count", 32'(bus.o_byte_count), 32'd8);

    // Asynchronous reset clears outputs without waiting for an edge
    #2;
    rst = 1'b1;
    #1;
    check("async_done", 32'(bus.o_done), 32'd0);
    check("async_count", 32'(bus.o_byte_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // An unaligned halt pattern does not stop the load
    prog2 = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_start(1'b0);
    for (int i = 0; i < 12; i++) send_byte(prog2[i], i, (i == 11));
    check("p2_count", 32'(bus.o_byte_count), 32'd12);

    // Back-to-back strobes give back-to-back writes
    do_start(1'b0);
    @(negedge clk);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'h11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) bus.i_rx_data = 8'h12 + 8'(i);
      else       bus.i_rx_valid = 1'b0;
      check("b2b_strobe", 32'(bus.o_write_instruction_mem), 32'd1);
      check("b2b_addr", bus.o_instruction_mem_addr, 32'(i));
      check("b2b_data", bus.o_instruction_mem_data, 32'h11 + 32'(i));
    end
    @(negedge clk);
    check("b2b_end", 32'(bus.o_write_instruction_mem), 32'd0);
    check("b2b_count", 32'(bus.o_byte_count), 32'd4);

    // Start during a load is ignored and addresses continue
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("midstart_count", 32'(bus.o_byte_count), 32'd4);
    send_byte(8'h77, 4, 1'b0);

    // Reset in the middle of a new load, then restart from address 0
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_start(1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), i, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_count", 32'(bus.o_byte_count), 32'd0);
    check("midrst_write", 32'(bus.o_write_instruction_mem), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_start(1'b1);
    send_byte(8'h3C, 0, 1'b0);
    send_byte(8'h3D, 1, 1'b0);

    // Overflow on the 8-byte instance
    @(negedge clk);
    bus8.i_start = 1'b1;
    @(negedge clk);
    bus8.i_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus8.i_rx_valid = 1'b1;
      bus8.i_rx_data  = 8'h00;
      @(negedge clk);
      bus8.i_rx_valid = 1'b0;
      if (i < 8) begin
        check("ov_write", 32'(bus8.o_write_instruction_mem), 32'd1);
        check("ov_addr", bus8.o_instruction_mem_addr, 32'(i));
      end else begin
        check("ov_nowrite", 32'(bus8.o_write_instruction_mem), 32'd0);
        check("ov_error", 32'(bus8.o_error), 32'd1);
        check("ov_busy", 32'(bus8.o_busy), 32'd0);
        check("ov_count", 32'(bus8.o_byte_count), 32'd8);
      end
    end
    @(negedge clk);
    bus8.i_start = 1'b1;
    @(negedge clk);
    bus8.i_start = 1'b0;
    check("ov_restart_error", 32'(bus8.o_error), 32'd0);
    check("ov_restart_count", 32'(bus8.o_byte_count), 32'd0);
    check("ov_restart_busy", 32'(bus8.o_busy), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Upstream feeder of the instruction fetch stage: receives program bytes from the UART receiver and writes them sequentially into the byte-wide instruction memory through the fetch stage's write port.
- Started by the debug unit. Holds the pipeline via o_busy while loading.
- Terminates on an aligned HALT_WORD or on memory overflow.

Parameters:
MEM_BYTES, 4096, instruction memory size in bytes (12-bit address space)
HALT_WORD, 32'hFFFFFFFF, instruction word that ends a program; it is written to memory, then loading stops
ADDR_WIDTH, 32, width of o_instruction_mem_addr

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-high reset
i_start  in  1  one-cycle pulse from debug unit: begin a new load at address 0
i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a new received byte
i_rx_data  in  8  received byte
o_write_instruction_mem  out  1  write strobe into instruction memory
o_instruction_mem_addr  out  ADDR_WIDTH  byte address of current write
o_instruction_mem_data  out  32  {24'b0, byte}; only the low byte is stored by the memory
o_busy  out  1  high in LOAD; drives fetch-stage halt/stall and address-mux select
o_done  out  1  level, high in DONE
o_error  out  1  level, high in ERROR (overflow)
o_byte_count  out  13  bytes written in current/last load (0..MEM_BYTES)

Behaviour:
- Reset (async, i_reset=1): state=IDLE; all outputs 0; byte counter=0; assembly shift register=0.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE/DONE/ERROR + i_start -> LOAD next edge.
  - Clear count, shift register, o_done, o_error.
  - i_rx_valid in the same cycle as i_start is ignored.
- LOAD + i_rx_valid, count < MEM_BYTES:
  - Next edge: o_write_instruction_mem=1 for exactly one cycle, addr=count (zero-extended), data={24'b0,i_rx_data}.
  - count increments by 1.
  - Shift register updates: sr <= {sr[23:0], i_rx_data}.
  - Latency: byte strobe at edge n -> write visible in cycle after edge n. Back-to-back strobes produce back-to-back writes at consecutive addresses.
- Byte order: bytes arrive MSB-first within each instruction word; byte k of word w is stored at address 4w+k.
- Halt detection: a byte that completes an aligned word (count[1:0]==3 before increment) with {sr[23:0], byte}==HALT_WORD is still written; the state goes to DONE on the same edge.
  - o_busy falls and o_done rises in the cycle that carries that final write.
  - An unaligned HALT_WORD pattern does not terminate loading.
- Overflow: LOAD + i_rx_valid with count==MEM_BYTES -> ERROR. No write occurs, and count holds at MEM_BYTES.
- LOAD + i_start: ignored (no restart mid-load).
- DONE/ERROR + i_rx_valid: ignored, no write.
- o_busy = (state==LOAD). o_done = (state==DONE). o_error = (state==ERROR). All are registered.
- o_write_instruction_mem is 0 in every cycle not caused by an accepted byte.
- o_instruction_mem_addr and o_instruction_mem_data hold their last values when no write is in progress.
- Reset mid-load: immediate return to IDLE with outputs 0. Partially written memory is not cleared.

Test Plan:
- Reset then idle: assert i_reset mid-cycle -> all outputs 0 asynchronously; i_rx_valid strobes in IDLE -> no write strobes.
- Single program: i_start, then bytes 20,08,00,05 and FF,FF,FF,FF -> 8 writes at addr 0..7 with data 0x20,0x08,0x00,0x05,0xFF×4; o_done=1 in the cycle of the addr-7 write; o_byte_count=8; o_busy=0.
- Unaligned halt pattern: bytes 00,FF,FF,FF,FF,00,00,00 -> all 8 written, still LOAD, o_done=0. Then FF×4 -> done at count=12.
- Back-to-back strobes: i_rx_valid high 4 consecutive cycles with 0x11..0x14 -> 4 consecutive one-cycle write pulses at addr 0..3, one cycle latency each.
- Overflow: with MEM_BYTES=8, send 9 bytes of 0x00 -> 8 writes; 9th byte gives o_error=1, no 9th write, o_byte_count=8. Then i_start -> o_error=0, count=0, LOAD.
- Reset mid-load and restart: after 3 bytes pulse i_reset -> IDLE, count 0. i_start plus a new program -> writes restart at addr 0. i_start during LOAD is ignored (addresses continue).
